instr_packer: RTL and testbench

INSTR_PACKER -- requirements
Module: instr_packer

---
 rtl/instr_packer_pkg.sv | 23 ++
 rtl/instr_encode.sv | 30 +++
 rtl/instr_packer.sv | 100 ++++++++++
 tb/tb_instr_packer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_packer_pkg.sv
// Shared ISA definitions: field widths, format encodings and packer FSM states.
// Used by the packer, the encoder and the instruction register.
package instr_packer_pkg;

   localparam int OP_W   = 4;
   localparam int REG_W  = 3;
   localparam int WORD_W = 16;
   localparam int ADDR_W = 16;
   localparam int CNT_W  = 8;

   typedef enum logic [1:0] {
      FMT_R   = 2'b00,
      FMT_I   = 2'b01,
      FMT_J   = 2'b10,
      FMT_ILL = 2'b11
   } fmt_e;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/instr_encode.sv
// Combinational field-to-word encoder; flags the reserved format instead of
// producing a word for it.
module instr_encode
   import instr_packer_pkg::*;
(
   input  logic [1:0]        fmt,
   input  logic [OP_W-1:0]   op_code,
   input  logic [REG_W-1:0]  ir1,
   input  logic [REG_W-1:0]  ir2,
   input  logic [REG_W-1:0]  ir3,
   input  logic [5:0]        imm6,
   input  logic [8:0]        imm9,
   input  logic [1:0]        cb,
   output logic [WORD_W-1:0] word,
   output logic              illegal
);

   always_comb begin
      // NOTE: defaults first, so no path through the case can infer a latch.
      word    = '0;
      illegal = 1'b0;
      case (fmt_e'(fmt))
         FMT_R:   word = {op_code, ir1, ir2, ir3, 1'b0, cb};
         FMT_I:   word = {op_code, ir1, ir2, imm6};
         FMT_J:   word = {op_code, ir1, imm9};
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_packer.sv
// Packs instruction field sets into 16-bit words and writes them to
// consecutive instruction-memory addresses with a stall-able write strobe.
module instr_packer
   import instr_packer_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  count,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        fmt,
   input  logic [OP_W-1:0]   op_code,
   input  logic [REG_W-1:0]  ir1,
   input  logic [REG_W-1:0]  ir2,
   input  logic [REG_W-1:0]  ir3,
   input  logic [5:0]        imm6,
   input  logic [8:0]        imm9,
   input  logic [1:0]        cb,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   logic [1:0]        state;
   logic [CNT_W-1:0]  remaining;
   logic [WORD_W-1:0] enc_word;
   logic              enc_illegal;
   logic              accept;
   logic              write_accept;
   logic              complete;

   instr_encode u_encode (
      .fmt     (fmt),
      .op_code (op_code),
      .ir1     (ir1),
      .ir2     (ir2),
      .ir3     (ir3),
      .imm6    (imm6),
      .imm9    (imm9),
      .cb      (cb),
      .word    (enc_word),
      .illegal (enc_illegal)
   );

   // A completing write frees the output register in the same cycle,
   // which is what allows back-to-back writes without a bubble.
   assign in_ready     = (state == ST_RUN) && (remaining != '0) && (!mem_we || mem_ready);
   assign accept       = in_valid && in_ready;
   assign write_accept = accept && !enc_illegal;
   assign complete     = mem_we && mem_ready;
   assign busy         = (state == ST_RUN) || (state == ST_DRAIN);
   assign done         = (state == ST_DONE);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         remaining <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_data  <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               state     <= ST_RUN;
               remaining <= count;
               mem_addr  <= base_addr;
               err       <= 1'b0;
            end
            ST_RUN: if (remaining == '0)
               state <= (mem_we && !mem_ready) ? ST_DRAIN : ST_DONE;
            ST_DRAIN: if (complete) state <= ST_DONE;
            ST_DONE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase

         // mem_addr doubles as the address counter; wraps naturally at 16 bits.
         if (complete) mem_addr <= mem_addr + 16'd1;

         if (accept && enc_illegal) err <= 1'b1;

         if (write_accept) begin
            remaining <= remaining - 8'd1;
            mem_we    <= 1'b1;
            mem_data  <= enc_word;
         end else if (complete) begin
            mem_we <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_packer.sv
// Randomised bench for instr_packer against a queue-based model of the
// expected write stream, plus directed boundary runs.
module tb_instr_packer;

   typedef struct packed {
      logic [1:0] fm;
      logic [3:0] op;
      logic [2:0] r1;
      logic [2:0] r2;
      logic [2:0] r3;
      logic [5:0] i6;
      logic [8:0] i9;
      logic [1:0] cb;
   } fs_t;

   logic        clk, reset, start, in_valid, in_ready, mem_we, mem_ready;
   logic        busy, done, err;
   logic [15:0] base_addr, mem_addr, mem_data;
   logic [7:0]  count;
   logic [1:0]  fmt, cb;
   logic [3:0]  op_code;
   logic [2:0]  ir1, ir2, ir3;
   logic [5:0]  imm6;
   logic [8:0]  imm9;

   int errors = 0;
   int checks = 0;

   fs_t         dir_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] log_q[$];

   instr_packer dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
      .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .op_code(op_code),
      .ir1(ir1), .ir2(ir2), .ir3(ir3), .imm6(imm6), .imm9(imm9), .cb(cb),
      .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .busy(busy), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic fs_t mk(input int fm, op, r1, r2, r3, i6, i9, c);
      fs_t f;
      f.fm = 2'(fm); f.op = 4'(op); f.r1 = 3'(r1); f.r2 = 3'(r2); f.r3 = 3'(r3);
      f.i6 = 6'(i6); f.i9 = 9'(i9); f.cb = 2'(c);
      return f;
   endfunction

   function automatic fs_t rand_fields(input int ill_pct);
      fs_t f;
      f = fs_t'({$urandom, $urandom});
      f.fm = ($urandom_range(0, 99) < ill_pct) ? 2'b11 : 2'($urandom_range(0, 2));
      return f;
   endfunction

   // Reference encoding: place-value arithmetic on the documented bit positions.
   function automatic logic [15:0] enc(input fs_t f);
      int w;
      case (f.fm)
         2'b00:   w = int'(f.op) * 4096 + int'(f.r1) * 512 + int'(f.r2) * 64 + int'(f.r3) * 8 + int'(f.cb);
         2'b01:   w = int'(f.op) * 4096 + int'(f.r1) * 512 + int'(f.r2) * 64 + int'(f.i6);
         default: w = int'(f.op) * 4096 + int'(f.r1) * 512 + int'(f.i9);
      endcase
      return 16'(w);
   endfunction

   task automatic apply(input fs_t f);
      fmt = f.fm; op_code = f.op; ir1 = f.r1; ir2 = f.r2; ir3 = f.r3;
      imm6 = f.i6; imm9 = f.i9; cb = f.cb;
   endtask

   task automatic run_pkt(input logic [15:0] base, input int cnt, input int ill_pct,
                          input bit stall_first, input int ready_pct);
      int          legal, writes, cyc, dones, hold;
      bit          any_ill, stalled_once, prev_stall;
      logic [15:0] prev_a, prev_d;
      logic [31:0] e;
      fs_t         f;
      legal = 0; writes = 0; cyc = 0; dones = 0; hold = 0;
      any_ill = 0; stalled_once = 0; prev_stall = 0; prev_a = '0; prev_d = '0;
      exp_q.delete();
      log_q.delete();
      @(negedge clk);
      start = 1'b1; base_addr = base; count = 8'(cnt); in_valid = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (dones == 0 && cyc < 2000) begin
         f = (dir_q.size() > 0) ? dir_q[0] : rand_fields(ill_pct);
         apply(f);
         in_valid = ($urandom_range(0, 99) < 70);
         if (stall_first && mem_we && !stalled_once) begin
            hold = 4;
            stalled_once = 1;
         end
         if (hold > 0) begin
            mem_ready = 1'b0;
            hold--;
         end else begin
            mem_ready = ($urandom_range(0, 99) < ready_pct);
         end
         #1;
         check("busy", busy, !done);
         check("err", err, any_ill);
         if (done) begin
            dones++;
            check("done_in_ready", in_ready, 0);
            check("done_no_we", mem_we, 0);
            if (cnt == 0) check("zero_done_cycle", cyc, 1);
         end
         if (prev_stall) begin
            check("hold_we", mem_we, 1);
            check("hold_addr", mem_addr, prev_a);
            check("hold_data", mem_data, prev_d);
         end
         if (mem_we && !mem_ready) check("stall_in_ready", in_ready, 0);
         if (legal == cnt) check("drained_in_ready", in_ready, 0);
         if (mem_we && mem_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_write", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", mem_addr, e[31:16]);
               check("wr_data", mem_data, e[15:0]);
            end
            log_q.push_back({mem_addr, mem_data});
            writes++;
         end
         if (in_valid && in_ready) begin
            if (f.fm == 2'b11) begin
               any_ill = 1;
            end else begin
               exp_q.push_back({16'(int'(base) + legal), enc(f)});
               legal++;
            end
            if (dir_q.size() > 0) void'(dir_q.pop_front());
         end
         prev_stall = mem_we && !mem_ready;
         prev_a = mem_addr;
         prev_d = mem_data;
         cyc++;
         @(negedge clk);
      end
      check("run_finished", dones, 1);
      check("write_count", writes, cnt);
      check("exp_empty", exp_q.size(), 0);
      check("idle_after_done", {busy, done, in_ready, mem_we}, 0);
      in_valid = 1'b0;
      dir_q.delete();
   endtask

   task automatic reset_mid_write();
      int n;
      @(negedge clk);
      start = 1'b1; base_addr = 16'h1234; count = 8'd3; mem_ready = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      apply(mk(1, 5, 1, 2, 0, 9, 0, 0));
      in_valid = 1'b1;
      n = 0;
      while (!mem_we && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rst_we_pending", {mem_we, mem_ready}, 2'b10);
      in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("rst_we_dropped", mem_we, 0);
      check("rst_flags", {busy, done, in_ready, err}, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_data", mem_data, 0);
      reset = 1'b0;
      mem_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("rst_no_done", {done, busy, mem_we}, 0);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0;
      mem_ready = 1'b0;
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
      repeat (3) @(negedge clk);
      check("reset_in_ready", in_ready, 0);
      check("reset_we", mem_we, 0);
      check("reset_addr", mem_addr, 0);
      check("reset_data", mem_data, 0);
      check("reset_flags", {busy, done, err}, 0);
      reset = 1'b0;

      // Documented three-word run with fixed fields.
      dir_q.push_back(mk(0, 0, 1, 2, 3, 0, 0, 2));
      dir_q.push_back(mk(1, 1, 4, 5, 0, 6'h2A, 0, 0));
      dir_q.push_back(mk(2, 3, 7, 0, 0, 0, 9'h1FF, 0));
      run_pkt(16'h0010, 3, 0, 0, 100);
      check("dir_log_size", log_q.size(), 3);
      if (log_q.size() == 3) begin
         check("dir_w0", log_q[0], 32'h0010_029A);
         check("dir_w1", log_q[1], 32'h0011_196A);
         check("dir_w2", log_q[2], 32'h0012_3FFF);
      end

      // First write stalled for four cycles.
      run_pkt(16'h0200, 4, 0, 1, 100);
      check("stall_log_size", log_q.size(), 4);

      // Address wrap.
      run_pkt(16'hFFFF, 2, 0, 0, 100);
      if (log_q.size() == 2) begin
         check("wrap_a0", log_q[0][31:16], 16'hFFFF);
         check("wrap_a1", log_q[1][31:16], 16'h0000);
      end else begin
         check("wrap_log_size", log_q.size(), 2);
      end

      // Illegal format mid-run: skipped, flagged, run still completes.
      dir_q.push_back(mk(1, 9, 3, 3, 0, 6'h11, 0, 0));
      dir_q.push_back(mk(3, 15, 7, 7, 7, 6'h3F, 9'h1FF, 3));
      dir_q.push_back(mk(2, 4, 2, 0, 0, 0, 9'h0A5, 0));
      run_pkt(16'h0300, 2, 0, 0, 100);
      check("err_sticky", err, 1);

      // Zero-length run.
      run_pkt(16'h0400, 0, 0, 0, 100);

      reset_mid_write();
      run_pkt(16'h0500, 3, 0, 0, 100);

      for (int i = 0; i < 8; i++)
         run_pkt(16'($urandom), $urandom_range(1, 16), 15, 0, 60);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
